// File: rtl/cvxif_copro_responder_if.sv
// CV-X-IF issue/commit/result channel bundle between core and coprocessor.
// master = core side, slave = coprocessor responder side.
interface cvxif_copro_responder_if #(
    parameter int XLEN     = 64,
    parameter int ID_WIDTH = 3
);
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [31:0]         issue_instr_i;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic [XLEN-1:0]     issue_rs1_i;
    logic [XLEN-1:0]     issue_rs2_i;
    logic                issue_accept_o;
    logic                issue_writeback_o;
    logic                commit_valid_i;
    logic [ID_WIDTH-1:0] commit_id_i;
    logic                commit_kill_i;
    logic                result_valid_o;
    logic                result_ready_i;
    logic [ID_WIDTH-1:0] result_id_o;
    logic [4:0]          result_rd_o;
    logic [XLEN-1:0]     result_data_o;
    logic                result_we_o;

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i,
        output issue_rs1_i, issue_rs2_i,
        output commit_valid_i, commit_id_i, commit_kill_i,
        output result_ready_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o,
        input  result_valid_o, result_id_o, result_rd_o,
        input  result_data_o, result_we_o
    );

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i,
        input  issue_rs1_i, issue_rs2_i,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        input  result_ready_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o,
        output result_valid_o, result_id_o, result_rd_o,
        output result_data_o, result_we_o
    );
endinterface

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: custom-3 ADD/XOR/SLL with in-order result buffer.
// Optional SLL support via `define CVXIF_COPRO_SLL_EN.
module cvxif_copro_responder #(
    parameter int XLEN     = 64,
    parameter int ID_WIDTH = 3,
    parameter int DEPTH    = 4
) (
    input logic                   clk_i,
    input logic                   rst_i,
    cvxif_copro_responder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {FREE, WAIT, READY, KILLED} st_e;

    st_e                 st_q [DEPTH];
    st_e                 st_n [DEPTH];
    logic [ID_WIDTH-1:0] id_q   [DEPTH];
    logic [4:0]          rd_q   [DEPTH];
    logic [XLEN-1:0]     data_q [DEPTH];
    logic [PW-1:0]       head_q, tail_q;
    logic [PW:0]         cnt_q, cnt_n;
    logic                rdy_q;

    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic            dec_ok;
    logic [XLEN-1:0] res;
    logic            fire, ret_ok, ret_kill, retire;
    logic            unused_fields;

    assign opc = bus.issue_instr_i[6:0];
    assign f3  = bus.issue_instr_i[14:12];
    assign f7  = bus.issue_instr_i[31:25];
    assign unused_fields = ^bus.issue_instr_i[24:15];

    always_comb begin
        dec_ok = 1'b0;
        res    = '0;
        if (opc == 7'b1111011 && f7 == 7'd0) begin
            unique case (1'b1)
                f3 == 3'd0: begin
                    dec_ok = 1'b1;
                    res    = bus.issue_rs1_i + bus.issue_rs2_i;
                end
                f3 == 3'd1: begin
                    dec_ok = 1'b1;
                    res    = bus.issue_rs1_i ^ bus.issue_rs2_i;
                end
`ifdef CVXIF_COPRO_SLL_EN
                f3 == 3'd2: begin
                    dec_ok = 1'b1;
                    res    = bus.issue_rs1_i << bus.issue_rs2_i[$clog2(XLEN)-1:0];
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.issue_accept_o    = dec_ok;
    assign bus.issue_writeback_o = dec_ok;
    assign bus.issue_ready_o     = rdy_q;

    assign fire     = bus.issue_valid_i && rdy_q && dec_ok;
    assign ret_ok   = (st_q[head_q] == READY) && bus.result_ready_i;
    assign ret_kill = (st_q[head_q] == KILLED);
    assign retire   = ret_ok || ret_kill;

    // Commit resolves WAIT entries, including the one being enqueued now.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            st_n[i] = st_q[i];
            if (bus.commit_valid_i && st_q[i] == WAIT &&
                id_q[i] == bus.commit_id_i)
                st_n[i] = bus.commit_kill_i ? KILLED : READY;
        end
        if (retire)
            st_n[head_q] = FREE;
        if (fire) begin
            st_n[tail_q] = WAIT;
            if (bus.commit_valid_i && bus.commit_id_i == bus.issue_id_i)
                st_n[tail_q] = bus.commit_kill_i ? KILLED : READY;
        end
        cnt_n = cnt_q + (PW+1)'(fire) - (PW+1)'(retire);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                st_q[i] <= FREE;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            st_q  <= st_n;
            cnt_q <= cnt_n;
            rdy_q <= (cnt_n != (PW+1)'(DEPTH));
            if (fire)
                tail_q <= tail_q + 1'b1;
            if (retire)
                head_q <= head_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) begin
            id_q[tail_q]   <= bus.issue_id_i;
            rd_q[tail_q]   <= bus.issue_instr_i[11:7];
            data_q[tail_q] <= res;
        end
    end

    logic hv;

    always_comb begin
        hv                 = (st_q[head_q] == READY);
        bus.result_valid_o = hv;
        bus.result_we_o    = hv;
        bus.result_id_o    = '0;
        bus.result_rd_o    = '0;
        bus.result_data_o  = '0;
        if (hv) begin
            bus.result_id_o   = id_q[head_q];
            bus.result_rd_o   = rd_q[head_q];
            bus.result_data_o = data_q[head_q];
        end
    end
endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Scoreboard bench for cvxif_copro_responder: in-order results, kills, full, reset.
// Honours CVXIF_COPRO_SLL_EN the same way as the design.
module tb_cvxif_copro_responder;
    localparam logic [6:0] OPC = 7'b1111011;

    typedef struct {
        logic [2:0]  id;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    cvxif_copro_responder_if #(.XLEN(64), .ID_WIDTH(3)) bus ();

    cvxif_copro_responder #(
        .XLEN(64), .ID_WIDTH(3), .DEPTH(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            pass_cnt++;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.result_valid_o && bus.result_ready_i) begin
            if (sb.size() == 0) begin
                chk("spurious_result", bus.result_valid_o, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_id", bus.result_id_o, e.id);
                chk("res_rd", bus.result_rd_o, e.rd);
                chk("res_data", bus.result_data_o, e.data);
                chk("res_we", bus.result_we_o, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] id, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [6:0] opc,
                         input logic [4:0] rd, input logic [63:0] a,
                         input logic [63:0] b, input bit acc,
                         input logic [63:0] data, input bit kill);
        exp_t e;
        bus.issue_valid_i = 1'b1;
        bus.issue_instr_i = {f7, 5'd2, 5'd1, f3, rd, opc};
        bus.issue_id_i    = id;
        bus.issue_rs1_i   = a;
        bus.issue_rs2_i   = b;
        @(negedge clk);
        chk("accept", bus.issue_accept_o, acc);
        chk("writeback", bus.issue_writeback_o, acc);
        if (acc && !kill && bus.issue_ready_o) begin
            e.id = id;
            e.rd = rd;
            e.data = data;
            sb.push_back(e);
        end
        tick();
        bus.issue_valid_i = 1'b0;
        bus.issue_instr_i = '0;
    endtask

    task automatic commit(input logic [2:0] id, input bit kill);
        bus.commit_valid_i = 1'b1;
        bus.commit_id_i    = id;
        bus.commit_kill_i  = kill;
        tick();
        bus.commit_valid_i = 1'b0;
        bus.commit_kill_i  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.result_valid_o) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sb.size(), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.issue_valid_i  = 1'b0;
        bus.issue_instr_i  = '0;
        bus.issue_id_i     = '0;
        bus.issue_rs1_i    = '0;
        bus.issue_rs2_i    = '0;
        bus.commit_valid_i = 1'b0;
        bus.commit_id_i    = '0;
        bus.commit_kill_i  = 1'b0;
        bus.result_ready_i = 1'b1;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", bus.issue_ready_o, 0);
        chk("rst_valid", bus.result_valid_o, 0);
        chk("rst_data", bus.result_data_o, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_first", bus.issue_ready_o, 0);
        @(negedge clk);
        chk("ready_rise", bus.issue_ready_o, 1);
        tick();

        // ADD with commit next cycle; result two cycles after issue
        issue(3'd1, 3'd0, 7'd0, OPC, 5'd3, 64'd5, 64'd7, 1, 64'd12, 0);
        bus.commit_valid_i = 1'b1;
        bus.commit_id_i    = 3'd1;
        @(negedge clk);
        chk("lat_early", bus.result_valid_o, 0);
        tick();
        bus.commit_valid_i = 1'b0;
        @(negedge clk);
        chk("lat_valid", bus.result_valid_o, 1);
        drain();

        // out-of-order commits, in-order results, held payload
        bus.result_ready_i = 1'b0;
        issue(3'd2, 3'd1, 7'd0, OPC, 5'd4, 64'hF0, 64'hFF, 1, 64'h0F, 0);
        issue(3'd3, 3'd0, 7'd0, OPC, 5'd5, 64'd100, 64'd23, 1, 64'd123, 0);
        commit(3'd3, 0);
        commit(3'd2, 0);
        tick();
        @(negedge clk);
        chk("hold_id", bus.result_id_o, 2);
        chk("hold_data", bus.result_data_o, 64'h0F);
        tick();
        @(negedge clk);
        chk("hold_id2", bus.result_id_o, 2);
        tick();
        bus.result_ready_i = 1'b1;
        drain();

        // killed entry produces no result
        issue(3'd4, 3'd0, 7'd0, OPC, 5'd6, 64'd1, 64'd1, 1, 64'd2, 1);
        commit(3'd4, 1);
        issue(3'd5, 3'd1, 7'd0, OPC, 5'd7, 64'hAAAA, 64'h5555, 1, 64'hFFFF, 0);
        commit(3'd5, 0);
        drain();

        // fill buffer, then free the head
        for (int i = 0; i < 4; i++)
            issue(3'(i), 3'd0, 7'd0, OPC, 5'(8 + i), 64'(i), 64'd1000,
                  1, 64'(1000 + i), 0);
        @(negedge clk);
        chk("full_ready", bus.issue_ready_o, 0);
        tick();
        commit(3'd0, 0);
        @(negedge clk);
        chk("full_retire_ready", bus.issue_ready_o, 0);
        chk("full_retire_valid", bus.result_valid_o, 1);
        @(negedge clk);
        chk("ready_back", bus.issue_ready_o, 1);
        tick();
        commit(3'd1, 0);
        commit(3'd2, 0);
        commit(3'd3, 0);
        drain();

        // rejected encodings, SLL, commit in enqueue cycle
        issue(3'd6, 3'd0, 7'd1, OPC, 5'd9, 64'd1, 64'd2, 0, 64'd0, 0);
        issue(3'd6, 3'd0, 7'd0, 7'b0001011, 5'd9, 64'd1, 64'd2, 0, 64'd0, 0);
        issue(3'd6, 3'd3, 7'd0, OPC, 5'd9, 64'd1, 64'd2, 0, 64'd0, 0);
`ifdef CVXIF_COPRO_SLL_EN
        issue(3'd6, 3'd2, 7'd0, OPC, 5'd10, 64'd1, 64'd68, 1, 64'd16, 0);
`else
        issue(3'd6, 3'd2, 7'd0, OPC, 5'd10, 64'd1, 64'd68, 0, 64'd0, 0);
`endif
        commit(3'd6, 0);
        drain();
        bus.commit_valid_i = 1'b1;
        bus.commit_id_i    = 3'd7;
        issue(3'd7, 3'd1, 7'd0, OPC, 5'd11, 64'h3, 64'h5, 1, 64'h6, 0);
        bus.commit_valid_i = 1'b0;
        @(negedge clk);
        chk("same_cycle_valid", bus.result_valid_o, 1);
        drain();

        // reset with pending entries and a presented result
        bus.result_ready_i = 1'b0;
        issue(3'd0, 3'd0, 7'd0, OPC, 5'd1, 64'd1, 64'd1, 1, 64'd2, 0);
        issue(3'd1, 3'd0, 7'd0, OPC, 5'd2, 64'd2, 64'd2, 1, 64'd4, 0);
        issue(3'd2, 3'd0, 7'd0, OPC, 5'd3, 64'd3, 64'd3, 1, 64'd6, 0);
        commit(3'd0, 0);
        @(negedge clk);
        chk("pre_rst_valid", bus.result_valid_o, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("post_rst_valid", bus.result_valid_o, 0);
        chk("post_rst_id", bus.result_id_o, 0);
        chk("post_rst_rd", bus.result_rd_o, 0);
        chk("post_rst_data", bus.result_data_o, 0);
        chk("post_rst_we", bus.result_we_o, 0);
        chk("post_rst_ready", bus.issue_ready_o, 0);
        chk("post_rst_accept", bus.issue_accept_o, 0);
        @(negedge clk);
        chk("post_rst_ready_rise", bus.issue_ready_o, 1);
        tick();
        bus.result_ready_i = 1'b1;
        commit(3'd1, 0);
        commit(3'd2, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_valid", bus.result_valid_o, 0);
        end
        tick();
        issue(3'd3, 3'd0, 7'd0, OPC, 5'd12, 64'd40, 64'd2, 1, 64'd42, 0);
        commit(3'd3, 0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/cvxif_copro_responder.md
# cvxif_copro_responder

Coprocessor-side responder for the CV-X-IF extension interface, the far end of the issue/commit/result channels the core drives when CVXIF is enabled. It decodes custom-3 instructions, accepts or rejects them in the issue cycle, and holds results in an in-order buffer until commit. It then returns a writeback result, or drops the entry on kill. It sits outside the core next to the CVXIF port, one instance per core.

## Interface
- XLEN, 64, operand/result width
- ID_WIDTH, 3, instruction ID width (8 scoreboard entries)
- DEPTH, 4, result buffer entries (power of two, ≥2)
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  responder can take an issue
- issue_instr_i  in  32  instruction word
- issue_id_i  in  ID_WIDTH  instruction ID
- issue_rs1_i / issue_rs2_i  in  XLEN  source operands (valid whenever issue_valid_i)
- issue_accept_o  out  1  instruction accepted (valid during issue handshake)
- issue_writeback_o  out  1  accepted instruction will write rd
- commit_valid_i  in  1  commit message valid (no ready; always taken)
- commit_id_i  in  ID_WIDTH  committed/killed ID
- commit_kill_i  in  1  1 = discard, 0 = commit
- result_valid_o  out  1  result valid
- result_ready_i  in  1  core takes result
- result_id_o  out  ID_WIDTH  result ID
- result_rd_o  out  5  destination register
- result_data_o  out  XLEN  result value
- result_we_o  out  1  write enable (always 1 when valid)

## Operation
- Decode: opcode[6:0]==7'b1111011 and funct7==0. funct3 0 = ADD rs1+rs2 (mod 2^XLEN); 1 = XOR; 2 = SLL rs1<<rs2[5:0]. Any other encoding is rejected.
- issue_accept_o / issue_writeback_o are combinational from issue_instr_i. When the encoding is rejected, both are 0 and nothing is enqueued.
- issue_ready_o = !full, registered from buffer occupancy. It is 0 during reset.
- On an accepted handshake, the entry {id, rd, computed data} is written at the tail in state WAIT. The tail pointer advances.
- Entry states: FREE → WAIT (accepted issue) → READY (commit, kill=0) or KILLED (commit, kill=1) → FREE (head retires).
- Commit matches commit_id_i associatively against WAIT entries.
  - A commit naming the ID being enqueued in the same cycle applies to that new entry.
  - A commit that matches no WAIT entry is ignored.
- Head retire:
  - READY head: drives the result registers. It is freed on result_valid_o && result_ready_i.
  - KILLED head: freed silently, one per cycle, with no result output.
- Results leave strictly in issue order, even when commits arrive out of order.
- The core guarantees that no in-flight ID is duplicated. Behaviour with duplicates is undefined.
- Occupancy counter 0..DEPTH. Pointers wrap modulo DEPTH. Issue and retire in the same cycle leave the count unchanged. A full buffer with a simultaneous retire still reports ready=0 that cycle.

## Timing
- Reset: all outputs 0, all entries FREE, pointers/count 0. A reset mid-operation drops all pending entries with no result. issue_ready_o rises the cycle after rst_i falls.
- Accept latency: 0 cycles (same cycle as the handshake).
- Result latency: issue at N, commit at M≥N. result_valid_o rises at max(M+1, head-available cycle).
- result_valid_o and its payload stay stable until accepted. The next READY head is presented in the cycle after acceptance (one result per cycle maximum).
- A KILLED head costs one cycle before the next head is considered.

## Configuration
- CVXIF_COPRO_SLL_EN
  - Defined: funct3=2 (SLL) is accepted and executed.
  - Undefined: funct3=2 is rejected (accept=0, not enqueued), and the shifter is removed.

## Test plan
- Issue ADD id=1 (rs1=5, rs2=7, rd=3), commit id=1 kill=0 next cycle, result_ready_i=1 → accept=1, writeback=1. Result id=1, rd=3, data=12 two cycles after issue.
- Issue id=2 XOR, then id=3 ADD; commit id=3 first, then id=2 → results come out id=2 then id=3 (in order).
- Issue id=4, commit id=4 kill=1, then issue/commit id=5 → no result for 4; id=5 result only.
- Issue DEPTH accepted instructions with no commits → issue_ready_o=0. Commit the head with result_ready_i=1 → ready returns the cycle after the retire.
- Issue funct7=1 and opcode 7'b0001011 → accept=0, writeback=0, occupancy unchanged. funct3=2 with rs1=1, rs2=64+4 → data=16 with macro defined; accept=0 without it.
- Assert rst_i with 3 pending entries and result_valid_o=1 → the next cycle has all outputs 0 and no stale results after reset.
